issue_queue_bank: RTL and testbench

Parametrised, self-registered issue queue for the out-of-order back end. It takes up to `DISPATCH_W` renamed instructions per cycle from rename/dispatch and holds them until both sources are ready. Source readiness is woken by `WAKEUP_PORTS` write-back broadcasts. It selects one ready entry per cycle for its functional unit through a valid/ready handshake and squashes wrong-path entries on branch recovery. One instance serves the integer pipe and one serves the memory pipe.

---
 rtl/mips_core_pkg.sv | 30 +++
 rtl/issue_queue_bank_if.sv | 50 +++++
 rtl/issue_age_matrix.sv | 43 ++++
 rtl/issue_queue_bank.sv | 183 ++++++++++++++++++
 tb/tb_issue_queue_bank.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared back-end types and defaults for the issue queue banks.
package mips_core_pkg;

    localparam int IQ_DEPTH        = 8;
    localparam int IQ_DISPATCH_W   = 2;
    localparam int IQ_WAKEUP_PORTS = 2;
    localparam int IQ_PREG_IDX     = 6;
    localparam int IQ_AL_IDX       = 5;
    localparam int IQ_PAYLOAD_W    = 64;

    typedef struct packed {
        logic                    valid;
        logic [IQ_PREG_IDX-1:0]  src1;
        logic                    rdy1;
        logic [IQ_PREG_IDX-1:0]  src2;
        logic                    rdy2;
        logic [IQ_AL_IDX-1:0]    al_id;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    // Distance of an active-list id from the head, modulo 2^width.
    function automatic int unsigned al_age(input int unsigned id,
                                           input int unsigned head,
                                           input int unsigned width);
        int unsigned mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (id - head) & mask;
    endfunction

endpackage

// File: rtl/issue_queue_bank_if.sv
// Dispatch, wakeup, issue and flush signals of one issue queue bank.
interface issue_queue_bank_if
    import mips_core_pkg::*;
#(
    parameter int DEPTH        = IQ_DEPTH,
    parameter int DISPATCH_W   = IQ_DISPATCH_W,
    parameter int WAKEUP_PORTS = IQ_WAKEUP_PORTS,
    parameter int PREG_IDX     = IQ_PREG_IDX,
    parameter int AL_IDX       = IQ_AL_IDX,
    parameter int PAYLOAD_W    = IQ_PAYLOAD_W
);
    logic [DISPATCH_W-1:0]                  disp_valid;
    logic                                   disp_ready;
    logic [DISPATCH_W-1:0][PREG_IDX-1:0]    disp_src1;
    logic [DISPATCH_W-1:0][PREG_IDX-1:0]    disp_src2;
    logic [DISPATCH_W-1:0]                  disp_src1_rdy;
    logic [DISPATCH_W-1:0]                  disp_src2_rdy;
    logic [DISPATCH_W-1:0][AL_IDX-1:0]      disp_al_id;
    logic [DISPATCH_W-1:0][PAYLOAD_W-1:0]   disp_payload;
    logic [WAKEUP_PORTS-1:0]                wb_valid;
    logic [WAKEUP_PORTS-1:0][PREG_IDX-1:0]  wb_preg;
    logic                                   iss_valid;
    logic                                   iss_ready;
    logic [PREG_IDX-1:0]                    iss_src1;
    logic [PREG_IDX-1:0]                    iss_src2;
    logic [AL_IDX-1:0]                      iss_al_id;
    logic [PAYLOAD_W-1:0]                   iss_payload;
    logic                                   flush_valid;
    logic                                   flush_all;
    logic [AL_IDX-1:0]                      flush_al_id;
    logic [AL_IDX-1:0]                      al_head;
    logic [$clog2(DEPTH):0]                 free_count;
    logic                                   empty;

    modport master (
        output disp_valid, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy,
               disp_al_id, disp_payload, wb_valid, wb_preg, iss_ready,
               flush_valid, flush_all, flush_al_id, al_head,
        input  disp_ready, iss_valid, iss_src1, iss_src2, iss_al_id, iss_payload,
               free_count, empty
    );

    modport slave (
        input  disp_valid, disp_src1, disp_src2, disp_src1_rdy, disp_src2_rdy,
               disp_al_id, disp_payload, wb_valid, wb_preg, iss_ready,
               flush_valid, flush_all, flush_al_id, al_head,
        output disp_ready, iss_valid, iss_src1, iss_src2, iss_al_id, iss_payload,
               free_count, empty
    );
endinterface

// File: rtl/issue_age_matrix.sv
// Older-than matrix for the issue queue; reports the oldest ready entry one-hot.
module issue_age_matrix #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DEPTH-1:0]             alloc,
    input  logic [DEPTH-1:0][DEPTH-1:0]  alloc_prior,
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0]             free,
    input  logic [DEPTH-1:0]             cand,
    output logic [DEPTH-1:0]             oldest
);
    // older[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0][DEPTH-1:0] older;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            older <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (free[i] || free[j])
                        older[i][j] <= 1'b0;
                    // A new entry is younger than all survivors and than earlier lanes
                    if (alloc[j])
                        older[i][j] <= (valid[i] && !free[i]) || alloc_prior[j][i];
                    else if (alloc[i])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            oldest[j] = cand[j];
            for (int i = 0; i < DEPTH; i++)
                if (cand[i] && older[i][j])
                    oldest[j] = 1'b0;
        end
    end
endmodule

// File: rtl/issue_queue_bank.sv
// Self-registered issue queue bank: dispatch, wakeup, single-issue select, flush.
// Define ISSUE_AGE_SELECT_EN for oldest-first select; otherwise lowest index wins.
module issue_queue_bank
    import mips_core_pkg::*;
#(
    parameter int DEPTH        = IQ_DEPTH,
    parameter int DISPATCH_W   = IQ_DISPATCH_W,
    parameter int WAKEUP_PORTS = IQ_WAKEUP_PORTS,
    parameter int PREG_IDX     = IQ_PREG_IDX,
    parameter int AL_IDX       = IQ_AL_IDX,
    parameter int PAYLOAD_W    = IQ_PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    issue_queue_bank_if.slave iq
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int LANE_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    logic [DEPTH-1:0]     valid, rdy1, rdy2;
    logic [PREG_IDX-1:0]  src1    [DEPTH];
    logic [PREG_IDX-1:0]  src2    [DEPTH];
    logic [AL_IDX-1:0]    al_id   [DEPTH];
    logic [PAYLOAD_W-1:0] payload [DEPTH];
    logic [CNT_W-1:0]     free_count;
    logic                 lock_vld;
    logic [DEPTH-1:0]     lock_oh;

    logic [WAKEUP_PORTS-1:0]               wb_valid;
    logic [WAKEUP_PORTS-1:0][PREG_IDX-1:0] wb_preg;
    logic                                  disp_ready, disp_fire, iss_fire, any_cand, lock_hit;
    logic                                  found;
    logic [DEPTH-1:0]                      slot_alloc, lane_mask, cand, pick, sel, freed, squash;
    logic [DEPTH-1:0][DEPTH-1:0]           slot_prior;
    logic [LANE_W-1:0]                     slot_lane [DEPTH];
    logic [CNT_W-1:0]                      n_alloc, n_freed, n_squash;
    int unsigned                           flush_age;

    assign wb_valid = iq.wb_valid;
    assign wb_preg  = iq.wb_preg;

    function automatic logic woken(input logic [PREG_IDX-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WAKEUP_PORTS; k++)
            if (wb_valid[k] && wb_preg[k] == tag)
                hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++)
            n = n + CNT_W'(v[i]);
        return n;
    endfunction

    assign disp_ready = (free_count >= CNT_W'(DISPATCH_W));
    assign disp_fire  = (|iq.disp_valid) && disp_ready && !iq.flush_valid;

    // Lane l takes the l-th lowest free slot
    always_comb begin
        slot_alloc = '0;
        slot_prior = '0;
        lane_mask  = '0;
        found      = 1'b0;
        for (int s = 0; s < DEPTH; s++)
            slot_lane[s] = '0;
        for (int l = 0; l < DISPATCH_W; l++) begin
            found = 1'b0;
            if (disp_fire && iq.disp_valid[l]) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (!found && !valid[s] && !lane_mask[s]) begin
                        found         = 1'b1;
                        slot_alloc[s] = 1'b1;
                        slot_lane[s]  = LANE_W'(l);
                        slot_prior[s] = lane_mask;
                        lane_mask[s]  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        flush_age = al_age(32'(iq.flush_al_id), 32'(iq.al_head), AL_IDX);
        for (int i = 0; i < DEPTH; i++)
            squash[i] = valid[i] && iq.flush_valid &&
                        (iq.flush_all ||
                         al_age(32'(al_id[i]), 32'(iq.al_head), AL_IDX) > flush_age);
    end

    assign cand = valid & rdy1 & rdy2;

`ifdef ISSUE_AGE_SELECT_EN
    issue_age_matrix #(.DEPTH(DEPTH)) u_age_matrix (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (slot_alloc),
        .alloc_prior (slot_prior),
        .valid       (valid),
        .free        (freed | squash),
        .cand        (cand),
        .oldest      (pick)
    );
`else
    always_comb begin
        pick = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (cand[i])
                pick = DEPTH'(1) << i;
    end
`endif

    // A stalled selection stays locked until the functional unit takes it
    assign lock_hit  = lock_vld && |(lock_oh & cand);
    assign sel       = lock_hit ? lock_oh : pick;
    assign any_cand  = |cand;
    assign iss_fire  = any_cand && !iq.flush_valid && iq.iss_ready;
    assign freed     = iss_fire ? sel : '0;
    assign n_alloc   = popcnt(slot_alloc);
    assign n_freed   = popcnt(freed);
    assign n_squash  = popcnt(squash);

    always_comb begin
        iq.iss_src1    = '0;
        iq.iss_src2    = '0;
        iq.iss_al_id   = '0;
        iq.iss_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                iq.iss_src1    = src1[i];
                iq.iss_src2    = src2[i];
                iq.iss_al_id   = al_id[i];
                iq.iss_payload = payload[i];
            end
        end
    end

    assign iq.iss_valid  = any_cand && !iq.flush_valid;
    assign iq.disp_ready = disp_ready;
    assign iq.free_count = free_count;
    assign iq.empty      = (free_count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid      <= '0;
            rdy1       <= '0;
            rdy2       <= '0;
            free_count <= CNT_W'(DEPTH);
            lock_vld   <= 1'b0;
        end else begin
            free_count <= free_count + n_freed + n_squash - n_alloc;
            lock_vld   <= iq.iss_valid && !iq.iss_ready;
            for (int i = 0; i < DEPTH; i++) begin
                if (squash[i] || freed[i])
                    valid[i] <= 1'b0;
                else if (slot_alloc[i])
                    valid[i] <= 1'b1;
                if (slot_alloc[i]) begin
                    rdy1[i] <= iq.disp_src1_rdy[slot_lane[i]] || woken(iq.disp_src1[slot_lane[i]]);
                    rdy2[i] <= iq.disp_src2_rdy[slot_lane[i]] || woken(iq.disp_src2[slot_lane[i]]);
                end else begin
                    rdy1[i] <= rdy1[i] || (valid[i] && woken(src1[i]));
                    rdy2[i] <= rdy2[i] || (valid[i] && woken(src2[i]));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        lock_oh <= sel;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_alloc[i]) begin
                src1[i]    <= iq.disp_src1[slot_lane[i]];
                src2[i]    <= iq.disp_src2[slot_lane[i]];
                al_id[i]   <= iq.disp_al_id[slot_lane[i]];
                payload[i] <= iq.disp_payload[slot_lane[i]];
            end
        end
    end
endmodule

// File: tb/tb_issue_queue_bank.sv
// Directed bench for issue_queue_bank: vector table plus multi-cycle sequences.
module tb_issue_queue_bank;
    import mips_core_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    issue_queue_bank_if bus ();

    issue_queue_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (bus)
    );

    typedef struct {
        string      name;
        logic [1:0] dv;
        logic [1:0] r1;
        logic [5:0] s1_0, s1_1;
        logic [4:0] id0, id1;
        logic [1:0] wbv;
        logic [5:0] wb0, wb1;
        logic       irdy;
        logic       e_iv;
        logic [4:0] e_id;
        logic [3:0] e_free;
        logic       e_dr;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    function automatic logic [63:0] pay(input logic [4:0] id);
        return {8{3'b101, id}};
    endfunction

    function automatic vec_t mk(input string nm, input logic [1:0] dv, input logic [1:0] r1,
                                input logic [5:0] s0, input logic [5:0] s1,
                                input logic [4:0] i0, input logic [4:0] i1,
                                input logic [1:0] wbv, input logic [5:0] w0, input logic [5:0] w1,
                                input logic irdy, input logic ev, input logic [4:0] eid,
                                input logic [3:0] efree, input logic edr);
        vec_t v;
        v.name = nm; v.dv = dv; v.r1 = r1; v.s1_0 = s0; v.s1_1 = s1;
        v.id0 = i0; v.id1 = i1; v.wbv = wbv; v.wb0 = w0; v.wb1 = w1;
        v.irdy = irdy; v.e_iv = ev; v.e_id = eid; v.e_free = efree; v.e_dr = edr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.disp_valid    = '0;
        bus.disp_src1     = '0;
        bus.disp_src2     = '0;
        bus.disp_src1_rdy = '0;
        bus.disp_src2_rdy = 2'b11;
        bus.disp_al_id    = '0;
        bus.disp_payload  = '0;
        bus.wb_valid      = '0;
        bus.wb_preg       = '0;
        bus.iss_ready     = 1'b0;
        bus.flush_valid   = 1'b0;
        bus.flush_all     = 1'b0;
        bus.flush_al_id   = '0;
        bus.al_head       = '0;
    endtask

    task automatic disp(input logic [1:0] dv, input logic [1:0] r1,
                        input logic [5:0] s0, input logic [5:0] s1,
                        input logic [4:0] i0, input logic [4:0] i1);
        bus.disp_valid      = dv;
        bus.disp_src1_rdy   = r1;
        bus.disp_src1[0]    = s0;
        bus.disp_src1[1]    = s1;
        bus.disp_al_id[0]   = i0;
        bus.disp_al_id[1]   = i1;
        bus.disp_payload[0] = pay(i0);
        bus.disp_payload[1] = pay(i1);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        vec[0]  = mk("reset_idle", 2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 0, 0, 8, 1);
        vec[1]  = mk("disp_pair",  2'b11, 2'b11,  0,  0, 1, 2, 2'b00,  0,  0, 1, 0, 0, 8, 1);
        vec[2]  = mk("iss_first",  2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 1, 1, 6, 1);
        vec[3]  = mk("iss_second", 2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 1, 2, 7, 1);
        vec[4]  = mk("drained",    2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 0, 0, 8, 1);
        vec[5]  = mk("race_disp",  2'b01, 2'b00, 12,  0, 3, 0, 2'b10,  0, 12, 1, 0, 0, 8, 1);
        vec[6]  = mk("race_iss",   2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 1, 3, 7, 1);
        vec[7]  = mk("split_disp", 2'b11, 2'b10, 20,  0, 4, 5, 2'b00,  0,  0, 1, 0, 0, 8, 1);
        vec[8]  = mk("stall_wake", 2'b00, 2'b00,  0,  0, 0, 0, 2'b01, 20,  0, 0, 1, 5, 6, 1);
        vec[9]  = mk("lock_hold",  2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 1, 5, 6, 1);
        vec[10] = mk("late_iss",   2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 1, 4, 7, 1);
        vec[11] = mk("drained2",   2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 0, 0, 8, 1);
        vec[12] = mk("miss_disp",  2'b01, 2'b00, 33,  0, 6, 0, 2'b01, 34,  0, 1, 0, 0, 8, 1);
        vec[13] = mk("miss_wait",  2'b00, 2'b00,  0,  0, 0, 0, 2'b10,  0, 33, 1, 0, 0, 7, 1);
        vec[14] = mk("wake_iss",   2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 1, 6, 7, 1);
        vec[15] = mk("drained3",   2'b00, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0, 1, 0, 0, 8, 1);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        chk("rst_free", 64'(bus.free_count), 64'd8);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_iss_al_id", 64'(bus.iss_al_id), 64'd0);
        chk("rst_iss_payload", bus.iss_payload, 64'd0);
        next();

        for (int i = 0; i < NV; i++) begin
            idle();
            disp(vec[i].dv, vec[i].r1, vec[i].s1_0, vec[i].s1_1, vec[i].id0, vec[i].id1);
            bus.wb_valid   = vec[i].wbv;
            bus.wb_preg[0] = vec[i].wb0;
            bus.wb_preg[1] = vec[i].wb1;
            bus.iss_ready  = vec[i].irdy;
            #1;
            chk({vec[i].name, "_iss_valid"}, 64'(bus.iss_valid), 64'(vec[i].e_iv));
            chk({vec[i].name, "_free"}, 64'(bus.free_count), 64'(vec[i].e_free));
            chk({vec[i].name, "_disp_ready"}, 64'(bus.disp_ready), 64'(vec[i].e_dr));
            if (vec[i].e_iv) begin
                chk({vec[i].name, "_al_id"}, 64'(bus.iss_al_id), 64'(vec[i].e_id));
                chk({vec[i].name, "_payload"}, bus.iss_payload, pay(vec[i].e_id));
            end
            next();
        end

        // Fill to 7 entries; refusal and one-cycle disp_ready recovery
        for (int c = 0; c < 3; c++) begin
            idle();
            disp(2'b11, 2'b00, 6'(50 + 2 * c), 6'(51 + 2 * c), 5'(7 + 2 * c), 5'(8 + 2 * c));
            next();
        end
        idle();
        disp(2'b01, 2'b00, 56, 0, 13, 0);
        next();
        idle();
        disp(2'b01, 2'b11, 0, 0, 14, 0);
        bus.wb_valid[0] = 1'b1;
        bus.wb_preg[0]  = 50;
        #1;
        chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
        chk("full_free", 64'(bus.free_count), 64'd1);
        chk("full_iss_valid", 64'(bus.iss_valid), 64'd0);
        next();
        idle();
        disp(2'b01, 2'b11, 0, 0, 14, 0);
        bus.iss_ready = 1'b1;
        #1;
        chk("full_refused_free", 64'(bus.free_count), 64'd1);
        chk("full_iss_edge_valid", 64'(bus.iss_valid), 64'd1);
        chk("full_iss_edge_id", 64'(bus.iss_al_id), 64'd7);
        chk("full_iss_edge_dr", 64'(bus.disp_ready), 64'd0);
        next();
        idle();
        #1;
        chk("after_iss_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("after_iss_free", 64'(bus.free_count), 64'd2);
        bus.flush_valid = 1'b1;
        bus.flush_all   = 1'b1;
        next();
        idle();
        #1;
        chk("fill_flush_empty", 64'(bus.empty), 64'd1);

        // Stall with a younger entry waking underneath
        disp(2'b11, 2'b01, 0, 40, 10, 11);
        next();
        idle();
        bus.wb_valid[0] = 1'b1;
        bus.wb_preg[0]  = 40;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_iss_valid", 64'(bus.iss_valid), 64'd1);
            chk("stall_al_id", 64'(bus.iss_al_id), 64'd10);
            next();
            idle();
        end
        bus.iss_ready = 1'b1;
        #1;
        chk("stall_release_id", 64'(bus.iss_al_id), 64'd10);
        next();
        idle();
        bus.iss_ready = 1'b1;
        #1;
        chk("stall_young_id", 64'(bus.iss_al_id), 64'd11);
        next();
        idle();
        #1;
        chk("stall_drained_free", 64'(bus.free_count), 64'd8);

        // Flush across the active-list wrap point
        bus.al_head = 30;
        disp(2'b11, 2'b01, 0, 60, 30, 31);
        next();
        idle();
        bus.al_head = 30;
        disp(2'b11, 2'b00, 61, 62, 0, 1);
        next();
        idle();
        bus.al_head     = 30;
        bus.iss_ready   = 1'b1;
        bus.flush_valid = 1'b1;
        bus.flush_al_id = 31;
        #1;
        chk("flush_iss_suppressed", 64'(bus.iss_valid), 64'd0);
        chk("flush_pre_free", 64'(bus.free_count), 64'd4);
        next();
        idle();
        bus.al_head = 30;
        #1;
        chk("flush_post_free", 64'(bus.free_count), 64'd6);
        chk("flush_branch_iss", 64'(bus.iss_valid), 64'd1);
        chk("flush_branch_id", 64'(bus.iss_al_id), 64'd30);
        disp(2'b11, 2'b11, 0, 0, 5, 6);
        bus.flush_valid = 1'b1;
        bus.flush_all   = 1'b1;
        next();
        idle();
        #1;
        chk("flush_all_empty", 64'(bus.empty), 64'd1);
        chk("flush_all_free", 64'(bus.free_count), 64'd8);
        chk("flush_all_iss", 64'(bus.iss_valid), 64'd0);

        // Reset mid-stream
        disp(2'b11, 2'b11, 0, 0, 20, 21);
        next();
        idle();
        bus.iss_ready = 1'b1;
        #1;
        chk("mid_iss_id", 64'(bus.iss_al_id), 64'd20);
        next();
        idle();
        bus.iss_ready = 1'b1;
        disp(2'b11, 2'b11, 0, 0, 22, 23);
        rst_n = 1'b0;
        #1;
        chk("mid_pre_rst_valid", 64'(bus.iss_valid), 64'd1);
        next();
        idle();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        chk("mid_rst_free", 64'(bus.free_count), 64'd8);
        chk("mid_rst_al_id", 64'(bus.iss_al_id), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
